score_to_bcd: RTL and testbench

SCORE_TO_BCD -- requirements
Module: score_to_bcd

---
 rtl/score_to_bcd.sv | 87 ++++++++
 tb/tb_score_to_bcd.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/score_to_bcd.sv
// score_to_bcd: serial double-dabble converter from binary score to two 5-bit display digits.
// Define LEADING_ZERO_BLANK_EN to blank a zero tens digit (code 5'b11111) on results and reset.
module score_to_bcd #(
  parameter int IN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] score,
  output logic            busy,
  output logic            done,
  output logic [4:0]      tens,
  output logic [4:0]      ones
);
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [4:0] TENS_RST = 5'b11111;
`else
  localparam logic [4:0] TENS_RST = 5'b00000;
`endif
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [7:0]      bcd_q, bcd_d, adj, step;
  logic [4:0]      tens_q, tens_d, ones_q, ones_d;
  logic            done_q, done_d;
  assign adj = {bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
                bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
  assign step = (adj << 1) | {7'b0, shift_q[IN_W-1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONV;
        cnt_d   = CW'(IN_W);
        shift_d = score;
        bcd_d   = 8'd0;
      end
    end else begin
      bcd_d   = step;
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CW'(1);
      // outputs change only here, so the display never shows a partial result
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        ones_d  = {1'b0, step[3:0]};
`ifdef LEADING_ZERO_BLANK_EN
        tens_d  = step[7:4] == 4'd0 ? 5'b11111 : {1'b0, step[7:4]};
`else
        tens_d  = {1'b0, step[7:4]};
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      tens_q  <= TENS_RST;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q == CONV;
  assign done = done_q;
  assign tens = tens_q;
  assign ones = ones_q;
endmodule

// File: tb/tb_score_to_bcd.sv
// tb_score_to_bcd: randomized scoreboard bench for score_to_bcd against an arithmetic digit model.
module tb_score_to_bcd;
  localparam int W = 6;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [4:0] RST_T = 5'd31;
`else
  localparam logic [4:0] RST_T = 5'd0;
`endif
  typedef struct {
    logic [4:0] t;
    logic [4:0] o;
    int         due;
  } exp_t;
  logic         clk, rst_n, start, busy, done;
  logic [W-1:0] score;
  logic [4:0]   tens, ones;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           last_a = -100;
  logic [4:0]   disp_t = RST_T;
  logic [4:0]   disp_o = 5'd0;
  exp_t         sb[$];
  score_to_bcd #(.IN_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .score(score),
    .busy(busy), .done(done), .tens(tens), .ones(ones)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask
  function automatic exp_t model(input int s, input int due);
    exp_t e;
    e.t   = 5'(s / 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (s / 10 == 0) e.t = 5'd31;
`endif
    e.o   = 5'(s % 10);
    e.due = due;
    return e;
  endfunction
  // call just after a falling edge; start is sampled at the next rising edge
  task automatic issue(input int s);
    int e;
    e     = cyc + 1;
    start = 1'b1;
    score = W'(s);
    if (e >= last_a + W + 1) begin
      last_a = e;
      sb.push_back(model(s, e + W));
    end
    @(negedge clk);
    start = 1'b0;
    score = W'($urandom_range(0, 63));
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("busy", busy, (cyc >= last_a && cyc < last_a + W) ? 1 : 0);
      check("done", done, (sb.size() > 0 && sb[0].due == cyc) ? 1 : 0);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected no pending result", cyc);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.due);
          disp_t = e.t;
          disp_o = e.o;
        end
      end
      check("tens", tens, disp_t);
      check("ones", ones, disp_o);
    end
  end
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    score = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tens", tens, RST_T);
    check("rst_ones", ones, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(21);
    repeat (8) @(negedge clk);
    issue(63);
    repeat (8) @(negedge clk);
    issue(0);
    repeat (8) @(negedge clk);
    issue(17);
    @(negedge clk);
    issue(9);
    repeat (8) @(negedge clk);
    issue(12);
    repeat (W) @(negedge clk);
    issue(30);
    repeat (9) @(negedge clk);
    issue(25);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tens", tens, RST_T);
    check("mid_rst_ones", ones, 0);
    sb.delete();
    last_a = -100;
    disp_t = RST_T;
    disp_o = 5'd0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int s = 0; s < 64; s++) begin
      issue(s);
      repeat (W - 1) @(negedge clk);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) issue($urandom_range(0, 63));
      else begin
        score = W'($urandom_range(0, 63));
        @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
